adc_scan_sched: RTL and testbench
=================================

ADC_SCAN_SCHED -- requirements
Module: adc_scan_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of logical channels (logical i maps to ADC channel i+1).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, maximum sys_clk cycles to wait for a response.
REQ-003 SHALL have ports: sys_clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: ch_enable in NUM_CH, channel mask; scan_start in 1, start pulse; cont_mode in 1, rescan continuously.
REQ-005 SHALL have ports: cmd_valid out 1; cmd_channel out 5; cmd_sop out 1; cmd_eop out 1; cmd_ready in 1 (ADC command stream).
REQ-006 SHALL have ports: rsp_valid in 1; rsp_channel in 5; rsp_data in 12 (ADC response stream).
REQ-007 SHALL have ports: sample_valid out 1, 1-cycle pulse; sample_idx out 3, logical channel; sample_mv out 13, millivolts.
REQ-008 SHALL have ports: rd_idx in 3; rd_mv out 13, stored value of channel rd_idx; busy out 1; scan_done out 1, pulse; timeout_err out 1, sticky.

Function
REQ-009 SHALL implement FSM IDLE, ISSUE, WAIT_RSP, DONE; one command outstanding at a time.
REQ-010 IDLE: scan_start=1 SHALL latch ch_enable into scan_mask, set index to 0 and go to ISSUE; scan_start is ignored outside IDLE.
REQ-011 ISSUE: SHALL select the lowest enabled index >= current index; if none remain, go to DONE without issuing.
REQ-012 ISSUE: cmd_valid=1, cmd_channel=index+1, cmd_sop=cmd_eop=1; cmd_channel SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-013 Command transfer SHALL occur on a cycle with cmd_valid=1 and cmd_ready=1; cmd_valid SHALL drop the next cycle; FSM goes to WAIT_RSP.
REQ-014 WAIT_RSP: rsp_valid=1 with rsp_channel=index+1 SHALL be accepted; index increments and FSM returns to ISSUE.
REQ-015 WAIT_RSP: rsp_valid=1 with a mismatched channel SHALL be discarded, with no output pulse and no state change.
REQ-016 WAIT_RSP: a timeout counter starts at 0 on entry; when it reaches TIMEOUT_CYC, timeout_err SHALL set, index increments and FSM goes to ISSUE.
REQ-017 Conversion: mv = floor(rsp_data*5000/4095), 25-bit intermediate; rsp_data 4095 -> 5000, 0 -> 0.
REQ-018 sample_valid, sample_idx and sample_mv SHALL assert exactly 1 cycle after an accepted response; the value SHALL also be written to store[index].
REQ-019 rd_mv SHALL be registered: it equals store[rd_idx] one cycle after rd_idx is applied; an out-of-range rd_idx returns 0.
REQ-020 DONE: scan_done SHALL pulse for 1 cycle; if cont_mode=1, relatch ch_enable, set index 0 and go to ISSUE; otherwise go to IDLE.
REQ-021 An all-zero mask SHALL produce no commands, and scan_done SHALL pulse 2 cycles after scan_start.
REQ-022 Changes to ch_enable mid-scan SHALL have no effect until the next latch point.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 timeout_err SHALL be cleared only by a scan_start accepted in IDLE or by reset.

Reset
REQ-025 On reset_n=0, asynchronously: FSM=IDLE; cmd_valid=0; cmd_channel=0; cmd_sop=cmd_eop=0; sample_valid=0; sample_idx=0; sample_mv=0; rd_mv=0; busy=0; scan_done=0; timeout_err=0; all store entries=0; index and counter=0.
REQ-026 Reset mid-transfer SHALL abandon the outstanding command; a late response after reset is discarded because the FSM is in IDLE.

Structure
REQ-027 Package adc_sched_pkg SHALL hold the FSM state enum, MV_FULL_SCALE=5000, ADC_FULL_CODE=4095 and ADC_CH_OFFSET=1.
REQ-028 Sub-module adc_mv_conv SHALL perform the combinational code-to-millivolt conversion; the register stage sits in adc_scan_sched.

Verification
REQ-029 Mask 8'b0000_0101, scan_start, cmd_ready=1, response code 4095 -> commands on channels 1 then 3; sample_mv=5000 with idx 0 then 2; one scan_done.
REQ-030 cmd_ready held 0 for 5 cycles -> cmd_valid=1 and cmd_channel constant for 5 cycles; exactly one transfer.
REQ-031 Never respond, TIMEOUT_CYC=15 -> timeout_err=1 16 cycles after transfer; next enabled channel issued; no sample_valid.
REQ-032 Response code 2048 on a wrong channel, then on the correct channel -> first discarded; sample_mv=2500 once.
REQ-033 cont_mode=1 with mask 0x01 -> back-to-back scans, scan_done per scan; drop cont_mode -> IDLE after current scan.
REQ-034 Mask 0 -> scan_done 2 cycles after start, no cmd_valid; reset_n=0 during WAIT_RSP -> all outputs at reset values immediately.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC scan scheduler: FSM encoding,
// stream field widths and the code-to-millivolt scaling constants.
package adc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_DONE
   } sched_state_t;

   localparam int MV_FULL_SCALE = 5000;
   localparam int ADC_FULL_CODE = 4095;
   localparam int ADC_CH_OFFSET = 1;

   localparam int CODE_W = 12;
   localparam int MV_W   = 13;
   localparam int CH_W   = 5;
   localparam int PROD_W = 25;

endpackage

// File: rtl/adc_mv_conv.sv
// Combinational ADC code to millivolt conversion: floor(code * 5000 / 4095).
// The product needs 25 bits (4095 * 5000 < 2^25); the quotient fits in 13.
module adc_mv_conv
   import adc_sched_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [MV_W-1:0]   mv
);

   function automatic logic [MV_W-1:0] code_to_mv(input logic [CODE_W-1:0] c);
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(c) * PROD_W'(MV_FULL_SCALE);
      return MV_W'(prod / PROD_W'(ADC_FULL_CODE));
   endfunction

   assign mv = code_to_mv(code);

endmodule

// File: rtl/adc_scan_sched.sv
// Scans the enabled ADC channels one command at a time, converts each
// response to millivolts, stores it per channel and flags lost responses.
module adc_scan_sched
   import adc_sched_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic              scan_start,
   input  logic              cont_mode,
   output logic              cmd_valid,
   output logic [CH_W-1:0]   cmd_channel,
   output logic              cmd_sop,
   output logic              cmd_eop,
   input  logic              cmd_ready,
   input  logic              rsp_valid,
   input  logic [CH_W-1:0]   rsp_channel,
   input  logic [CODE_W-1:0] rsp_data,
   output logic              sample_valid,
   output logic [2:0]        sample_idx,
   output logic [MV_W-1:0]   sample_mv,
   input  logic [2:0]        rd_idx,
   output logic [MV_W-1:0]   rd_mv,
   output logic              busy,
   output logic              scan_done,
   output logic              timeout_err
);

   localparam int IDX_W = $clog2(NUM_CH + 1);
   localparam int SEL_W = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   sched_state_t      state;
   sched_state_t      state_nxt;
   logic [NUM_CH-1:0] scan_mask;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  next_sel;
   logic              next_found;
   logic [CNT_W-1:0]  tmo_cnt;
   logic [CH_W-1:0]   exp_ch;
   logic [MV_W-1:0]   mv_p0;
   logic [MV_W-1:0]   store [NUM_CH];
   logic              start_acc;
   logic              latch_mask;
   logic              xfer;
   logic              rsp_hit;
   logic              tmo_hit;

   // Lowest enabled logical channel at or above the current index.
   always_comb begin
      next_found = 1'b0;
      next_sel   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (scan_mask[i] && (i >= int'(idx))) begin
            next_found = 1'b1;
            next_sel   = IDX_W'(i);
         end
      end
   end

   assign exp_ch    = CH_W'(idx) + CH_W'(ADC_CH_OFFSET);
   assign busy      = (state != ST_IDLE);
   assign scan_done = (state == ST_DONE);

   always_comb begin
      state_nxt   = state;
      cmd_valid   = 1'b0;
      cmd_channel = '0;
      cmd_sop     = 1'b0;
      cmd_eop     = 1'b0;
      start_acc   = 1'b0;
      latch_mask  = 1'b0;
      xfer        = 1'b0;
      rsp_hit     = 1'b0;
      tmo_hit     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (scan_start) begin
               start_acc  = 1'b1;
               latch_mask = 1'b1;
               state_nxt  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!next_found) begin
               state_nxt = ST_DONE;
            end else begin
               // Channel held steady by idx/scan_mask staying put until transfer.
               cmd_valid   = 1'b1;
               cmd_channel = CH_W'(next_sel) + CH_W'(ADC_CH_OFFSET);
               cmd_sop     = 1'b1;
               cmd_eop     = 1'b1;
               if (cmd_ready) begin
                  xfer      = 1'b1;
                  state_nxt = ST_WAIT_RSP;
               end
            end
         end
         ST_WAIT_RSP: begin
            if (rsp_valid && (rsp_channel == exp_ch)) begin
               rsp_hit   = 1'b1;
               state_nxt = ST_ISSUE;
            end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC)) begin
               tmo_hit   = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_DONE: begin
            if (cont_mode) begin
               latch_mask = 1'b1;
               state_nxt  = ST_ISSUE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_mask   <= '0;
         idx         <= '0;
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (latch_mask) begin
            scan_mask <= ch_enable;
            idx       <= '0;
         end
         if (start_acc) begin
            timeout_err <= 1'b0;
         end
         if (xfer) begin
            idx     <= next_sel;
            tmo_cnt <= '0;
         end else if (state == ST_WAIT_RSP) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
         if (rsp_hit || tmo_hit) begin
            idx <= idx + IDX_W'(1);
         end
         if (tmo_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

   adc_mv_conv u_conv (
      .code (rsp_data),
      .mv   (mv_p0)
   );

   // p0 -> p1: conversion result registered on the accepting edge.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_valid <= 1'b0;
         sample_idx   <= '0;
         sample_mv    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            store[i] <= '0;
         end
      end else begin
         sample_valid <= rsp_hit;
         if (rsp_hit) begin
            sample_idx             <= 3'(idx);
            sample_mv              <= mv_p0;
            store[SEL_W'(idx)]     <= mv_p0;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_mv <= '0;
      end else if (int'(rd_idx) < NUM_CH) begin
         rd_mv <= store[SEL_W'(rd_idx)];
      end else begin
         rd_mv <= '0;
      end
   end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed bench for adc_scan_sched: every scenario is a task with its own
// hand-computed expectations, run in sequence from one initial block.
module tb_adc_scan_sched;

   localparam int NUM_CH = 8;
   localparam int TMO    = 15;

   logic              sys_clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NUM_CH-1:0] ch_enable = '0;
   logic              scan_start = 1'b0;
   logic              cont_mode = 1'b0;
   logic              cmd_valid;
   logic [4:0]        cmd_channel;
   logic              cmd_sop;
   logic              cmd_eop;
   logic              cmd_ready = 1'b0;
   logic              rsp_valid = 1'b0;
   logic [4:0]        rsp_channel = '0;
   logic [11:0]       rsp_data = '0;
   logic              sample_valid;
   logic [2:0]        sample_idx;
   logic [12:0]       sample_mv;
   logic [2:0]        rd_idx = '0;
   logic [12:0]       rd_mv;
   logic              busy;
   logic              scan_done;
   logic              timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   adc_scan_sched #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(TMO)) dut (
      .sys_clk      (sys_clk),
      .reset_n      (reset_n),
      .ch_enable    (ch_enable),
      .scan_start   (scan_start),
      .cont_mode    (cont_mode),
      .cmd_valid    (cmd_valid),
      .cmd_channel  (cmd_channel),
      .cmd_sop      (cmd_sop),
      .cmd_eop      (cmd_eop),
      .cmd_ready    (cmd_ready),
      .rsp_valid    (rsp_valid),
      .rsp_channel  (rsp_channel),
      .rsp_data     (rsp_data),
      .sample_valid (sample_valid),
      .sample_idx   (sample_idx),
      .sample_mv    (sample_mv),
      .rd_idx       (rd_idx),
      .rd_mv        (rd_mv),
      .busy         (busy),
      .scan_done    (scan_done),
      .timeout_err  (timeout_err)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b exp 0", busy); end
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_cmd_valid got %0b exp 0", cmd_valid); end
      n_cmp++; if ({cmd_channel, cmd_sop, cmd_eop} !== 7'd0) begin n_err++; $display("FAIL rst_cmd_fields got %0h exp 0", {cmd_channel, cmd_sop, cmd_eop}); end
      n_cmp++; if ({sample_valid, sample_idx, sample_mv} !== 17'd0) begin n_err++; $display("FAIL rst_sample got %0h exp 0", {sample_valid, sample_idx, sample_mv}); end
      n_cmp++; if (rd_mv !== 13'd0) begin n_err++; $display("FAIL rst_rd_mv got %0d exp 0", rd_mv); end
      n_cmp++; if ({scan_done, timeout_err} !== 2'b00) begin n_err++; $display("FAIL rst_done_tmo got %b exp 00", {scan_done, timeout_err}); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_scan();
      ch_enable = 8'b0000_0101; cmd_ready = 1'b1; scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      n_cmp++; if ({cmd_valid, cmd_channel} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL basic_cmd1 got v=%0b ch=%0d exp v=1 ch=1", cmd_valid, cmd_channel); end
      n_cmp++; if ({cmd_sop, cmd_eop, busy} !== 3'b111) begin n_err++; $display("FAIL basic_sop_eop_busy got %b exp 111", {cmd_sop, cmd_eop, busy}); end
      tick();
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got %0b exp 0", cmd_valid); end
      rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'd4095;
      tick();
      rsp_valid = 1'b0;
      n_cmp++; if ({sample_valid, sample_idx, sample_mv} !== {1'b1, 3'd0, 13'd5000}) begin n_err++; $display("FAIL basic_sample0 got v=%0b i=%0d mv=%0d exp v=1 i=0 mv=5000", sample_valid, sample_idx, sample_mv); end
      n_cmp++; if ({cmd_valid, cmd_channel} !== {1'b1, 5'd3}) begin n_err++; $display("FAIL basic_cmd3 got v=%0b ch=%0d exp v=1 ch=3", cmd_valid, cmd_channel); end
      tick();
      n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL basic_sample_pulse got %0b exp 0", sample_valid); end
      rsp_valid = 1'b1; rsp_channel = 5'd3; rsp_data = 12'd4095;
      tick();
      rsp_valid = 1'b0;
      n_cmp++; if ({sample_valid, sample_idx, sample_mv} !== {1'b1, 3'd2, 13'd5000}) begin n_err++; $display("FAIL basic_sample2 got v=%0b i=%0d mv=%0d exp v=1 i=2 mv=5000", sample_valid, sample_idx, sample_mv); end
      n_cmp++; if ({cmd_valid, scan_done} !== 2'b00) begin n_err++; $display("FAIL basic_no_more_cmd got %b exp 00", {cmd_valid, scan_done}); end
      tick();
      n_cmp++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL basic_scan_done got %0b exp 1", scan_done); end
      rd_idx = 3'd2;
      tick();
      n_cmp++; if ({scan_done, busy} !== 2'b00) begin n_err++; $display("FAIL basic_idle got %b exp 00", {scan_done, busy}); end
      n_cmp++; if (rd_mv !== 13'd5000) begin n_err++; $display("FAIL basic_rd2 got %0d exp 5000", rd_mv); end
      rd_idx = 3'd1;
      tick();
      n_cmp++; if (rd_mv !== 13'd0) begin n_err++; $display("FAIL basic_rd1 got %0d exp 0", rd_mv); end
   endtask

   task automatic test_backpressure();
      ch_enable = 8'h02; cmd_ready = 1'b0; scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      ch_enable = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if ({cmd_valid, cmd_channel} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL bp_hold%0d got v=%0b ch=%0d exp v=1 ch=2", k, cmd_valid, cmd_channel); end
         tick();
      end
      cmd_ready = 1'b1;
      n_cmp++; if ({cmd_valid, cmd_channel} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL bp_release got v=%0b ch=%0d exp v=1 ch=2", cmd_valid, cmd_channel); end
      tick();
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL bp_one_xfer got %0b exp 0", cmd_valid); end
      rsp_valid = 1'b1; rsp_channel = 5'd2; rsp_data = 12'd0;
      tick();
      rsp_valid = 1'b0;
      n_cmp++; if ({sample_valid, sample_idx, sample_mv} !== {1'b1, 3'd1, 13'd0}) begin n_err++; $display("FAIL bp_sample got v=%0b i=%0d mv=%0d exp v=1 i=1 mv=0", sample_valid, sample_idx, sample_mv); end
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL bp_mask_frozen got %0b exp 0", cmd_valid); end
      tick();
      tick();
      ch_enable = '0;
   endtask

   task automatic test_timeout();
      ch_enable = 8'h09; cmd_ready = 1'b1; scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      n_cmp++; if (cmd_channel !== 5'd1) begin n_err++; $display("FAIL tmo_cmd1 got %0d exp 1", cmd_channel); end
      tick();
      for (int k = 1; k <= TMO; k++) begin
         tick();
         n_cmp++; if ({timeout_err, sample_valid, cmd_valid} !== 3'b000) begin n_err++; $display("FAIL tmo_wait%0d got %b exp 000", k, {timeout_err, sample_valid, cmd_valid}); end
      end
      tick();
      n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_flag got %0b exp 1", timeout_err); end
      n_cmp++; if ({cmd_valid, cmd_channel, sample_valid} !== {1'b1, 5'd4, 1'b0}) begin n_err++; $display("FAIL tmo_next got v=%0b ch=%0d sv=%0b exp v=1 ch=4 sv=0", cmd_valid, cmd_channel, sample_valid); end
      tick();
      rsp_valid = 1'b1; rsp_channel = 5'd4; rsp_data = 12'd2048;
      tick();
      rsp_valid = 1'b0;
      n_cmp++; if ({sample_valid, sample_idx, sample_mv} !== {1'b1, 3'd3, 13'd2500}) begin n_err++; $display("FAIL tmo_sample got v=%0b i=%0d mv=%0d exp v=1 i=3 mv=2500", sample_valid, sample_idx, sample_mv); end
      tick();
      tick();
      n_cmp++; if ({busy, timeout_err} !== 2'b01) begin n_err++; $display("FAIL tmo_sticky got %b exp 01", {busy, timeout_err}); end
   endtask

   task automatic test_wrong_channel();
      ch_enable = 8'h04; scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL wc_tmo_clear got %0b exp 0", timeout_err); end
      n_cmp++; if ({cmd_valid, cmd_channel} !== {1'b1, 5'd3}) begin n_err++; $display("FAIL wc_cmd got v=%0b ch=%0d exp v=1 ch=3", cmd_valid, cmd_channel); end
      tick();
      rsp_valid = 1'b1; rsp_channel = 5'd5; rsp_data = 12'd2048;
      tick();
      n_cmp++; if ({sample_valid, busy, cmd_valid} !== 3'b010) begin n_err++; $display("FAIL wc_discard got %b exp 010", {sample_valid, busy, cmd_valid}); end
      rsp_channel = 5'd3;
      tick();
      rsp_valid = 1'b0;
      n_cmp++; if ({sample_valid, sample_idx, sample_mv} !== {1'b1, 3'd2, 13'd2500}) begin n_err++; $display("FAIL wc_sample got v=%0b i=%0d mv=%0d exp v=1 i=2 mv=2500", sample_valid, sample_idx, sample_mv); end
      tick();
      n_cmp++; if ({sample_valid, scan_done} !== 2'b01) begin n_err++; $display("FAIL wc_once_done got %b exp 01", {sample_valid, scan_done}); end
      rd_idx = 3'd2;
      tick();
      n_cmp++; if (rd_mv !== 13'd2500) begin n_err++; $display("FAIL wc_rd2 got %0d exp 2500", rd_mv); end
   endtask

   task automatic test_cont_mode();
      ch_enable = 8'h01; cont_mode = 1'b1; scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick();
      rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'd4095;
      tick();
      rsp_valid = 1'b0;
      tick();
      n_cmp++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL cont_done1 got %0b exp 1", scan_done); end
      tick();
      n_cmp++; if ({scan_done, busy, cmd_valid, cmd_channel} !== {3'b011, 5'd1}) begin n_err++; $display("FAIL cont_rescan got %b ch=%0d exp 011 ch=1", {scan_done, busy, cmd_valid}, cmd_channel); end
      cont_mode = 1'b0;
      tick();
      rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'd1000;
      tick();
      rsp_valid = 1'b0;
      n_cmp++; if ({sample_valid, sample_mv} !== {1'b1, 13'd1221}) begin n_err++; $display("FAIL cont_sample got v=%0b mv=%0d exp v=1 mv=1221", sample_valid, sample_mv); end
      tick();
      n_cmp++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL cont_done2 got %0b exp 1", scan_done); end
      tick();
      n_cmp++; if ({scan_done, busy} !== 2'b00) begin n_err++; $display("FAIL cont_stop got %b exp 00", {scan_done, busy}); end
   endtask

   task automatic test_zero_mask();
      ch_enable = 8'h00; scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      n_cmp++; if ({cmd_valid, scan_done, busy} !== 3'b001) begin n_err++; $display("FAIL zm_cycle1 got %b exp 001", {cmd_valid, scan_done, busy}); end
      tick();
      n_cmp++; if ({cmd_valid, scan_done} !== 2'b01) begin n_err++; $display("FAIL zm_done got %b exp 01", {cmd_valid, scan_done}); end
      tick();
      n_cmp++; if ({scan_done, busy} !== 2'b00) begin n_err++; $display("FAIL zm_idle got %b exp 00", {scan_done, busy}); end
   endtask

   task automatic test_reset_mid();
      ch_enable = 8'h01; cmd_ready = 1'b1; scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick();
      n_cmp++; if ({busy, cmd_valid} !== 2'b10) begin n_err++; $display("FAIL rm_wait got %b exp 10", {busy, cmd_valid}); end
      rd_idx = 3'd0;
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if ({busy, cmd_valid, scan_done, timeout_err, sample_valid} !== 5'd0) begin n_err++; $display("FAIL rm_async got %b exp 00000", {busy, cmd_valid, scan_done, timeout_err, sample_valid}); end
      n_cmp++; if ({rd_mv, sample_mv, cmd_channel} !== 31'd0) begin n_err++; $display("FAIL rm_data got rd=%0d smv=%0d ch=%0d exp 0", rd_mv, sample_mv, cmd_channel); end
      #2 reset_n = 1'b1;
      rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'd4095;
      tick();
      rsp_valid = 1'b0;
      n_cmp++; if ({sample_valid, busy} !== 2'b00) begin n_err++; $display("FAIL rm_late_rsp got %b exp 00", {sample_valid, busy}); end
      tick();
      n_cmp++; if (rd_mv !== 13'd0) begin n_err++; $display("FAIL rm_store_clear got %0d exp 0", rd_mv); end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_backpressure();
      test_timeout();
      test_wrong_channel();
      test_cont_mode();
      test_zero_mask();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
